// File: rtl/ddr_arb_pkg.sv
// Shared widths, FSM encoding and requester indices for the DDR3 system-port arbiter.
package ddr_arb_pkg;

    localparam int ARB_ADDR_W = 27;
    localparam int ARB_DATA_W = 16;
    localparam int ARB_STAT_W = 32;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_ARB  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ddr_arb_rr_pick.sv
// Two-way round-robin winner: a lone requester wins, a tie goes to the port not granted last.
module ddr_arb_rr_pick
    import ddr_arb_pkg::*;
(
    input  logic valid_a_i,
    input  logic valid_b_i,
    input  logic last_grant_i,
    output logic grant_valid_o,
    output logic grant_o
);

    always_comb begin
        grant_valid_o = valid_a_i | valid_b_i;
        if (valid_a_i && valid_b_i) begin
            grant_o = ~last_grant_i;
        end else if (valid_b_i) begin
            grant_o = PORT_B;
        end else begin
            grant_o = PORT_A;
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares the single slowDDR3 system port between requesters A and B, one transaction in flight.
// Optional per-port completion counters are built when ARB_STATS_EN is defined.
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
`ifdef ARB_STATS_EN
    ,
    parameter int STAT_W = ARB_STAT_W
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reqa_valid,
    input  logic              reqa_we,
    input  logic [ADDR_W-1:0] reqa_addr,
    input  logic [DATA_W-1:0] reqa_wdata,
    output logic              reqa_ready,
    output logic              rspa_valid,
    output logic [DATA_W-1:0] rspa_rdata,
    input  logic              reqb_valid,
    input  logic              reqb_we,
    input  logic [ADDR_W-1:0] reqb_addr,
    input  logic [DATA_W-1:0] reqb_wdata,
    output logic              reqb_ready,
    output logic              rspb_valid,
    output logic [DATA_W-1:0] rspb_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [DATA_W-1:0] mem_wr_payload,
    output logic              mem_rd_ready,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_payload,
`ifdef ARB_STATS_EN
    output logic [STAT_W-1:0] stat_a_cnt,
    output logic [STAT_W-1:0] stat_b_cnt,
`endif
    input  logic              init_fin
);

    arb_state_e        state_q;
    logic              last_grant_q;
    logic              owner_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic              mem_wr_valid_q;
    logic [DATA_W-1:0] mem_wr_payload_q;
    logic              mem_rd_ready_q;
    logic              rspa_valid_q;
    logic              rspb_valid_q;
    logic [DATA_W-1:0] rspa_rdata_q;
    logic [DATA_W-1:0] rspb_rdata_q;

    logic              grant_valid;
    logic              grant;
    logic              accept;
    logic              done;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    ddr_arb_rr_pick u_pick (
        .valid_a_i     (reqa_valid),
        .valid_b_i     (reqb_valid),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_o       (grant)
    );

    always_comb begin
        accept     = (state_q == ST_ARB) && grant_valid;
        reqa_ready = accept && (grant == PORT_A);
        reqb_ready = accept && (grant == PORT_B);
        sel_we     = (grant == PORT_A) ? reqa_we    : reqb_we;
        sel_addr   = (grant == PORT_A) ? reqa_addr  : reqb_addr;
        sel_wdata  = (grant == PORT_A) ? reqa_wdata : reqb_wdata;
        done       = ((state_q == ST_WR) && mem_wr_ready) ||
                     ((state_q == ST_RD) && mem_rd_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_INIT;
            last_grant_q     <= PORT_B;
            owner_q          <= PORT_A;
            mem_address_q    <= '0;
            mem_wr_valid_q   <= 1'b0;
            mem_wr_payload_q <= '0;
            mem_rd_ready_q   <= 1'b0;
            rspa_valid_q     <= 1'b0;
            rspb_valid_q     <= 1'b0;
            rspa_rdata_q     <= '0;
            rspb_rdata_q     <= '0;
        end else begin
            rspa_valid_q <= done && (owner_q == PORT_A);
            rspb_valid_q <= done && (owner_q == PORT_B);
            case (state_q)
                ST_INIT: begin
                    if (init_fin) state_q <= ST_ARB;
                end
                ST_ARB: begin
                    if (accept) begin
                        owner_q       <= grant;
                        last_grant_q  <= grant;
                        mem_address_q <= sel_addr;
                        if (sel_we) begin
                            mem_wr_valid_q   <= 1'b1;
                            mem_wr_payload_q <= sel_wdata;
                            state_q          <= ST_WR;
                        end else begin
                            mem_rd_ready_q <= 1'b1;
                            state_q        <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    if (mem_wr_ready) begin
                        mem_wr_valid_q   <= 1'b0;
                        mem_address_q    <= '0;
                        mem_wr_payload_q <= '0;
                        state_q          <= ST_ARB;
                    end
                end
                ST_RD: begin
                    if (mem_rd_valid) begin
                        mem_rd_ready_q <= 1'b0;
                        mem_address_q  <= '0;
                        if (owner_q == PORT_A) rspa_rdata_q <= mem_rd_payload;
                        else                   rspb_rdata_q <= mem_rd_payload;
                        state_q        <= ST_ARB;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] stat_a_q;
    logic [STAT_W-1:0] stat_b_q;

    // Counters step on the same edge that raises the response pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_a_q <= '0;
            stat_b_q <= '0;
        end else if (done) begin
            if (owner_q == PORT_A) stat_a_q <= stat_a_q + STAT_W'(1);
            else                   stat_b_q <= stat_b_q + STAT_W'(1);
        end
    end

    assign stat_a_cnt = stat_a_q;
    assign stat_b_cnt = stat_b_q;
`endif

    assign mem_address    = mem_address_q;
    assign mem_wr_valid   = mem_wr_valid_q;
    assign mem_wr_payload = mem_wr_payload_q;
    assign mem_rd_ready   = mem_rd_ready_q;
    assign rspa_valid     = rspa_valid_q;
    assign rspb_valid     = rspb_valid_q;
    assign rspa_rdata     = rspa_rdata_q;
    assign rspb_rdata     = rspb_rdata_q;

endmodule
